// File: rtl/dpram_arb_pkg.sv
// Shared types and helpers for the dual-port RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dpram_arb_pkg;

    localparam int DPRAM_DATA_W = 8;
    localparam int DPRAM_ADDR_W = 6;

    // Which RAM port a read return comes from
    typedef enum logic [1:0] {
        PORT_A,
        PORT_B,
        PORT_NONE
    } port_sel_e;

    // Rotating index wrap; idx is always below 2*n at every call site
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/dpram_arbiter_rr_pick.sv
// Rotating-priority picker: first eligible bit at or after start, wrapping.
// Latency: combinational.
// Backpressure: none; pick_vld low when nothing is eligible.
module rr_pick
    import dpram_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int IDXW = 2
) (
    input  logic [N-1:0]    elig,
    input  logic [IDXW-1:0] start,
    output logic            pick_vld,
    output logic [N-1:0]    pick_oh,
    output logic [IDXW-1:0] pick_idx
);

    logic [IDXW-1:0] cand;

    // Scan from start upward and keep the first eligible candidate
    always_comb begin
        pick_vld = 1'b0;
        pick_oh  = '0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDXW'(rr_wrap(int'(start) + k, N));
            if (!pick_vld && elig[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
        if (pick_vld) pick_oh[pick_idx] = 1'b1;
    end

endmodule

// File: rtl/dpram_arbiter.sv
// Round-robin arbiter sharing both DualPortRam ports among NUM_REQ requesters.
// Latency: grant/RAM drive same cycle; read data + rvalid one cycle after grant.
// Backpressure: gnt is the ready; ungranted requests are held by the requester.
// Optional: define DPRAM_ARB_COLL_CNT_EN to enable the saturating collision counter.
module dpram_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DPRAM_DATA_W,
    parameter int ADDR_W  = DPRAM_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [NUM_REQ*DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0]         ram_addr_a,
    output logic [ADDR_W-1:0]         ram_addr_b,
    output logic [DATA_W-1:0]         ram_data_a,
    output logic [DATA_W-1:0]         ram_data_b,
    output logic                      ram_we_a,
    output logic                      ram_we_b,
    input  logic [DATA_W-1:0]         ram_q_a,
    input  logic [DATA_W-1:0]         ram_q_b,
    output logic [15:0]               coll_cnt
);

    localparam int IDXW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_eff, a_oh, b_oh, b_elig, conflict;
    logic                      a_vld, b_vld, a_we, b_we;
    logic [IDXW-1:0]           a_idx, b_idx, b_start, last_idx;
    logic [ADDR_W-1:0]         a_addr, b_addr;
    logic [DATA_W-1:0]         a_wdata, b_wdata;
    logic [IDXW-1:0]           rr_ptr_q, rr_ptr_d;
    logic                      rd_a_vld_q, rd_a_vld_d, rd_b_vld_q, rd_b_vld_d;
    logic [IDXW-1:0]           rd_a_own_q, rd_a_own_d, rd_b_own_q, rd_b_own_d;
    logic [NUM_REQ*DATA_W-1:0] rdata_q, rdata_d;
    port_sel_e                 src;

    // Nothing is granted or driven onto the RAM while reset is held
    assign req_eff = rst_n ? req : '0;

    rr_pick #(.N(NUM_REQ), .IDXW(IDXW)) u_pick_a (
        .elig     (req_eff),
        .start    (rr_ptr_q),
        .pick_vld (a_vld),
        .pick_oh  (a_oh),
        .pick_idx (a_idx)
    );

    // Port A winner's request fields (zero when port A idles)
    always_comb begin
        a_addr  = '0;
        a_wdata = '0;
        a_we    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (a_oh[i]) begin
                a_addr  = req_addr[i*ADDR_W +: ADDR_W];
                a_wdata = req_wdata[i*DATA_W +: DATA_W];
                a_we    = req_we[i];
            end
        end
    end

    // Same-address candidates are skipped for port B unless both are reads
    always_comb begin
        conflict = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            conflict[i] = a_vld && (req_addr[i*ADDR_W +: ADDR_W] == a_addr) && (req_we[i] || a_we);
        end
        b_elig  = req_eff & ~a_oh & ~conflict;
        b_start = IDXW'(rr_wrap(int'(a_idx) + 1, NUM_REQ));
    end

    rr_pick #(.N(NUM_REQ), .IDXW(IDXW)) u_pick_b (
        .elig     (b_elig),
        .start    (b_start),
        .pick_vld (b_vld),
        .pick_oh  (b_oh),
        .pick_idx (b_idx)
    );

    // Port B winner's request fields (zero when port B idles)
    always_comb begin
        b_addr  = '0;
        b_wdata = '0;
        b_we    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (b_oh[i]) begin
                b_addr  = req_addr[i*ADDR_W +: ADDR_W];
                b_wdata = req_wdata[i*DATA_W +: DATA_W];
                b_we    = req_we[i];
            end
        end
    end

    assign gnt        = a_oh | b_oh;
    assign ram_addr_a = a_addr;
    assign ram_data_a = a_wdata;
    assign ram_we_a   = a_we;
    assign ram_addr_b = b_addr;
    assign ram_data_b = b_wdata;
    assign ram_we_b   = b_we;

    // Next pointer sits just past the last winner; read owners recorded for the return cycle
    always_comb begin
        last_idx   = b_vld ? b_idx : a_idx;
        rr_ptr_d   = a_vld ? IDXW'(rr_wrap(int'(last_idx) + 1, NUM_REQ)) : rr_ptr_q;
        rd_a_vld_d = a_vld && !a_we;
        rd_a_own_d = a_idx;
        rd_b_vld_d = b_vld && !b_we;
        rd_b_own_d = b_idx;
    end

    // Steer registered RAM output to the owning requester; others hold last data
    always_comb begin
        rvalid  = '0;
        rdata_d = rdata_q;
        src     = PORT_NONE;
        for (int i = 0; i < NUM_REQ; i++) begin
            src = PORT_NONE;
            if (rd_a_vld_q && rd_a_own_q == IDXW'(i))      src = PORT_A;
            else if (rd_b_vld_q && rd_b_own_q == IDXW'(i)) src = PORT_B;
            case (src)
                PORT_A: begin
                    rvalid[i]                   = 1'b1;
                    rdata_d[i*DATA_W +: DATA_W] = ram_q_a;
                end
                PORT_B: begin
                    rvalid[i]                   = 1'b1;
                    rdata_d[i*DATA_W +: DATA_W] = ram_q_b;
                end
                default: ;
            endcase
        end
    end

    assign rdata = rdata_d;

    // Arbitration pointer, outstanding-read tracking and per-requester read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            rd_a_vld_q <= 1'b0;
            rd_a_own_q <= '0;
            rd_b_vld_q <= 1'b0;
            rd_b_own_q <= '0;
            rdata_q    <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rd_a_vld_q <= rd_a_vld_d;
            rd_a_own_q <= rd_a_own_d;
            rd_b_vld_q <= rd_b_vld_d;
            rd_b_own_q <= rd_b_own_d;
            rdata_q    <= rdata_d;
        end
    end

`ifdef DPRAM_ARB_COLL_CNT_EN
    logic        coll_hit;
    logic [15:0] coll_cnt_q, coll_cnt_d;

    // Count cycles where some live request lost port B to an address conflict
    always_comb begin
        coll_hit   = |(req_eff & ~a_oh & conflict);
        coll_cnt_d = (coll_hit && coll_cnt_q != 16'hFFFF) ? coll_cnt_q + 16'd1 : coll_cnt_q;
    end

    // Saturating collision counter, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) coll_cnt_q <= '0;
        else        coll_cnt_q <= coll_cnt_d;
    end

    assign coll_cnt = coll_cnt_q;
`else
    assign coll_cnt = '0;
`endif

endmodule
